// File: rtl/pid_seq_ctrl_pkg.sv
// Shared definitions for the PID_16 configuration/sequencing controller:
// state encoding, host register map and the default core latency.
package pid_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2,
    ST_HOLD = 2'd3
  } state_e;

  localparam logic [2:0] A_RT    = 3'd0;
  localparam logic [2:0] A_K0    = 3'd1;
  localparam logic [2:0] A_K1    = 3'd2;
  localparam logic [2:0] A_K2    = 3'd3;
  localparam logic [2:0] A_SHIFT = 3'd4;
  localparam logic [2:0] A_MIN   = 3'd5;
  localparam logic [2:0] A_MAX   = 3'd6;
  localparam logic [2:0] A_DIV   = 3'd7;

  localparam int LAT_DEF = 12;

endpackage

// File: rtl/pid_seq_ctrl_if.sv
// Host register bus: one-word-per-cycle shadow writes plus a commit pulse.
interface pid_seq_ctrl_if;
  logic        i_wr_en;
  logic [2:0]  i_wr_addr;
  logic [31:0] i_wr_data;
  logic        i_commit;

  modport master (output i_wr_en, i_wr_addr, i_wr_data, i_commit);
  modport slave  (input  i_wr_en, i_wr_addr, i_wr_data, i_commit);
endinterface

// File: rtl/pid_cfg_bank.sv
// Shadow and active PID parameter registers with an atomic, checked commit.
module pid_cfg_bank
  import pid_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHIFT = 5,
  parameter int CNTW  = 16
) (
  input  logic               i_clkp,
  input  logic               i_rstn,
  input  logic               i_wr_en,
  input  logic [2:0]         i_wr_addr,
  input  logic [31:0]        i_wr_data,
  input  logic               i_commit,
  output logic [WIDTH-1:0]   o_rt,
  output logic [WIDTH-1:0]   o_k0,
  output logic [WIDTH-1:0]   o_k1,
  output logic [WIDTH-1:0]   o_k2,
  output logic [SHIFT-1:0]   o_shift,
  output logic [2*WIDTH-1:0] o_min,
  output logic [2*WIDTH-1:0] o_max,
  output logic [CNTW-1:0]    o_div,
  output logic               o_cfg_err
);

  logic [WIDTH-1:0]   sh_rt_q, sh_k0_q, sh_k1_q, sh_k2_q;
  logic [SHIFT-1:0]   sh_shift_q;
  logic [2*WIDTH-1:0] sh_min_q, sh_max_q;
  logic [CNTW-1:0]    sh_div_q;
  logic               err_q;
  logic               commit_ok;

  // Both-zero limits mean "unclamped" and are always accepted.
  assign commit_ok = !(($signed(sh_min_q) >= $signed(sh_max_q)) &&
                       !((sh_min_q == '0) && (sh_max_q == '0)));

  always_ff @(posedge i_clkp or negedge i_rstn) begin
    if (!i_rstn) begin
      sh_rt_q <= '0; sh_k0_q <= '0; sh_k1_q <= '0; sh_k2_q <= '0;
      sh_shift_q <= '0; sh_min_q <= '0; sh_max_q <= '0; sh_div_q <= '0;
    end else if (i_wr_en) begin
      case (i_wr_addr)
        A_RT:    sh_rt_q    <= i_wr_data[WIDTH-1:0];
        A_K0:    sh_k0_q    <= i_wr_data[WIDTH-1:0];
        A_K1:    sh_k1_q    <= i_wr_data[WIDTH-1:0];
        A_K2:    sh_k2_q    <= i_wr_data[WIDTH-1:0];
        A_SHIFT: sh_shift_q <= i_wr_data[SHIFT-1:0];
        A_MIN:   sh_min_q   <= i_wr_data[2*WIDTH-1:0];
        A_MAX:   sh_max_q   <= i_wr_data[2*WIDTH-1:0];
        default: sh_div_q   <= i_wr_data[CNTW-1:0];
      endcase
    end
  end

  // Commit reads the pre-edge shadow, so a same-cycle write is not included.
  always_ff @(posedge i_clkp or negedge i_rstn) begin
    if (!i_rstn) begin
      o_rt <= '0; o_k0 <= '0; o_k1 <= '0; o_k2 <= '0;
      o_shift <= '0; o_min <= '0; o_max <= '0; o_div <= '0;
      err_q <= 1'b0;
    end else if (i_commit) begin
      if (commit_ok) begin
        o_rt <= sh_rt_q; o_k0 <= sh_k0_q; o_k1 <= sh_k1_q; o_k2 <= sh_k2_q;
        o_shift <= sh_shift_q; o_min <= sh_min_q; o_max <= sh_max_q;
        o_div <= sh_div_q;
        err_q <= 1'b0;
      end else begin
        err_q <= 1'b1;
      end
    end
  end

  assign o_cfg_err = err_q;

endmodule

// File: rtl/pid_seq_ctrl.sv
// PID_16 sequencer: OFF/FILL/RUN/HOLD control, core reset, output republish
// with a decimated valid strobe. Parameter storage lives in pid_cfg_bank.
module pid_seq_ctrl
  import pid_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHIFT = 5,
  parameter int LAT   = LAT_DEF,
  parameter int CNTW  = 16
) (
  input  logic               i_clkp,
  input  logic               i_rstn,
  input  logic               i_enable,
  input  logic               i_hold,
  pid_seq_ctrl_if.slave      host,
  input  logic [2*WIDTH-1:0] i_ut,
  output logic               o_pid_rstn,
  output logic [WIDTH-1:0]   o_rt,
  output logic [WIDTH-1:0]   o_k0,
  output logic [WIDTH-1:0]   o_k1,
  output logic [WIDTH-1:0]   o_k2,
  output logic [SHIFT-1:0]   o_shift,
  output logic [2*WIDTH-1:0] o_min,
  output logic [2*WIDTH-1:0] o_max,
  output logic [2*WIDTH-1:0] o_ut,
  output logic               o_ut_valid,
  output logic [1:0]         o_state,
  output logic               o_cfg_err
);

  logic [WIDTH-1:0] k0_act, k1_act, k2_act;
  logic [CNTW-1:0]  div_act;

  pid_cfg_bank #(.WIDTH(WIDTH), .SHIFT(SHIFT), .CNTW(CNTW)) u_cfg (
    .i_clkp    (i_clkp),
    .i_rstn    (i_rstn),
    .i_wr_en   (host.i_wr_en),
    .i_wr_addr (host.i_wr_addr),
    .i_wr_data (host.i_wr_data),
    .i_commit  (host.i_commit),
    .o_rt      (o_rt),
    .o_k0      (k0_act),
    .o_k1      (k1_act),
    .o_k2      (k2_act),
    .o_shift   (o_shift),
    .o_min     (o_min),
    .o_max     (o_max),
    .o_div     (div_act),
    .o_cfg_err (o_cfg_err)
  );

  state_e             state_q, state_d;
  logic               off_seen_q, off_seen_d;
  logic [CNTW-1:0]    fill_cnt_q, fill_cnt_d;
  logic [CNTW-1:0]    dec_cnt_q, dec_cnt_d;
  logic [2*WIDTH-1:0] ut_q, ut_d;
  logic               vld_q, vld_d;
  logic               pid_rstn_q;

  always_ff @(posedge i_clkp or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q    <= ST_OFF;
      off_seen_q <= 1'b0;
      fill_cnt_q <= '0;
      dec_cnt_q  <= '0;
      ut_q       <= '0;
      vld_q      <= 1'b0;
      pid_rstn_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      off_seen_q <= off_seen_d;
      fill_cnt_q <= fill_cnt_d;
      dec_cnt_q  <= dec_cnt_d;
      ut_q       <= ut_d;
      vld_q      <= vld_d;
      pid_rstn_q <= (state_d != ST_OFF);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_OFF:  if (i_enable && off_seen_q) state_d = ST_FILL;
      ST_FILL: if (fill_cnt_q == CNTW'(LAT - 1)) state_d = i_hold ? ST_HOLD : ST_RUN;
      ST_RUN:  if (i_hold) state_d = ST_HOLD;
      default: if (!i_hold) state_d = ST_FILL;
    endcase
    if (!i_enable) state_d = ST_OFF;

    // off_seen marks that at least one full OFF cycle has already elapsed.
    off_seen_d = (state_q == ST_OFF) && (state_d == ST_OFF);
    fill_cnt_d = ((state_q == ST_FILL) && (state_d == ST_FILL)) ?
                 fill_cnt_q + CNTW'(1) : '0;

    // Output register is loaded per next state so o_ut/o_ut_valid align with o_state.
    ut_d      = ut_q;
    vld_d     = 1'b0;
    dec_cnt_d = dec_cnt_q;
    case (state_d)
      ST_OFF: ut_d = '0;
      ST_RUN: begin
        ut_d = i_ut;
        if ((state_q != ST_RUN) || (dec_cnt_q == '0)) begin
          vld_d     = 1'b1;
          dec_cnt_d = div_act;
        end else begin
          dec_cnt_d = dec_cnt_q - CNTW'(1);
        end
      end
      default: ;
    endcase
  end

  assign o_pid_rstn = pid_rstn_q;
  assign o_ut       = ut_q;
  assign o_ut_valid = vld_q;
  assign o_state    = state_q;
  // Zero gains in HOLD stop the incremental accumulator without resetting it.
  assign o_k0 = (state_q == ST_HOLD) ? '0 : k0_act;
  assign o_k1 = (state_q == ST_HOLD) ? '0 : k1_act;
  assign o_k2 = (state_q == ST_HOLD) ? '0 : k2_act;

endmodule

// File: tb/tb_pid_seq_ctrl.sv
// Directed bench for pid_seq_ctrl: config commit, sequencing, hold, decimation, reset.
module tb_pid_seq_ctrl;
  logic        clk = 1'b0;
  logic        rstn, enable, hold;
  logic [31:0] ut;
  logic        pid_rstn, ut_valid, cfg_err;
  logic [15:0] rt, k0, k1, k2;
  logic [4:0]  shift;
  logic [31:0] omin, omax, out;
  logic [1:0]  state;
  int total = 0;
  int bad   = 0;

  pid_seq_ctrl_if host();

  pid_seq_ctrl dut (
    .i_clkp(clk), .i_rstn(rstn), .i_enable(enable), .i_hold(hold),
    .host(host), .i_ut(ut),
    .o_pid_rstn(pid_rstn), .o_rt(rt), .o_k0(k0), .o_k1(k1), .o_k2(k2),
    .o_shift(shift), .o_min(omin), .o_max(omax), .o_ut(out),
    .o_ut_valid(ut_valid), .o_state(state), .o_cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    host.i_wr_en = 1'b1; host.i_wr_addr = a; host.i_wr_data = d;
    tick();
    host.i_wr_en = 1'b0;
  endtask

  task automatic commit();
    host.i_commit = 1'b1;
    tick();
    host.i_commit = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    total++; if ({pid_rstn, out, ut_valid, cfg_err, state} !== 36'h0) begin
      bad++; $display("FAIL reset_outs got=%h want=0", {pid_rstn, out, ut_valid, cfg_err, state}); end
    total++; if ({rt, k0, k1, k2, shift, omin, omax} !== '0) begin
      bad++; $display("FAIL reset_cfg got=%h want=0", {rt, k0, k1, k2, shift, omin, omax}); end
    tick();
    rstn = 1'b1;
  endtask

  task automatic test_commit_gains();
    wr(3'd1, 32'd3); wr(3'd2, 32'hFFFF_FFFE); wr(3'd3, 32'd1); wr(3'd4, 32'hFFFF_FFFF);
    total++; if ({k0, k1, k2, shift} !== '0) begin
      bad++; $display("FAIL no_commit got=%h want=0", {k0, k1, k2, shift}); end
    commit();
    total++; if (k0 !== 16'd3) begin bad++; $display("FAIL k0 got=%h want=0003", k0); end
    total++; if (k1 !== 16'hFFFE) begin bad++; $display("FAIL k1 got=%h want=fffe", k1); end
    total++; if (k2 !== 16'd1) begin bad++; $display("FAIL k2 got=%h want=0001", k2); end
    total++; if (shift !== 5'h1F) begin bad++; $display("FAIL shift got=%h want=1f", shift); end
  endtask

  task automatic test_limits();
    wr(3'd5, 32'd100); wr(3'd6, 32'd50); commit();
    total++; if ({omin, omax, cfg_err} !== {32'd0, 32'd0, 1'b1}) begin
      bad++; $display("FAIL lim_reject got=%h/%h/%b want=0/0/1", omin, omax, cfg_err); end
    wr(3'd6, 32'd200); commit();
    total++; if ({omin, omax, cfg_err} !== {32'd100, 32'd200, 1'b0}) begin
      bad++; $display("FAIL lim_accept got=%h/%h/%b want=64/c8/0", omin, omax, cfg_err); end
    wr(3'd5, 32'hFFFF_FFFB); commit();
    total++; if ({omin, cfg_err} !== {32'hFFFF_FFFB, 1'b0}) begin
      bad++; $display("FAIL lim_signed got=%h/%b want=fffffffb/0", omin, cfg_err); end
  endtask

  task automatic test_wr_commit_same();
    wr(3'd0, 32'd5); commit();
    host.i_wr_en = 1'b1; host.i_wr_addr = 3'd0; host.i_wr_data = 32'd9; host.i_commit = 1'b1;
    tick();
    host.i_wr_en = 1'b0; host.i_commit = 1'b0;
    total++; if (rt !== 16'd5) begin bad++; $display("FAIL same_cycle got=%h want=0005", rt); end
    commit();
    total++; if (rt !== 16'd9) begin bad++; $display("FAIL late_commit got=%h want=0009", rt); end
  endtask

  task automatic test_fill_run();
    ut = 32'hCAFE_0001; enable = 1'b1;
    tick();
    total++; if ({state, pid_rstn} !== {2'd1, 1'b1}) begin
      bad++; $display("FAIL fill_entry got=%0d/%b want=1/1", state, pid_rstn); end
    for (int i = 0; i < 11; i++) begin
      tick();
      total++; if ({state, ut_valid} !== {2'd1, 1'b0}) begin
        bad++; $display("FAIL fill_len i=%0d got=%0d/%b want=1/0", i, state, ut_valid); end
    end
    tick();
    total++; if ({state, ut_valid, out} !== {2'd2, 1'b1, 32'hCAFE_0001}) begin
      bad++; $display("FAIL run_entry got=%0d/%b/%h want=2/1/cafe0001", state, ut_valid, out); end
    for (int i = 0; i < 3; i++) begin
      ut = 32'h100 + i;
      tick();
      total++; if ({ut_valid, out} !== {1'b1, 32'h100 + i}) begin
        bad++; $display("FAIL run_follow i=%0d got=%b/%h want=1/%h", i, ut_valid, out, 32'h100 + i); end
    end
  endtask

  task automatic test_hold();
    hold = 1'b1; ut = 32'h0000_DEAD;
    tick();
    total++; if ({state, k0, k1, k2, ut_valid} !== {2'd3, 48'd0, 1'b0}) begin
      bad++; $display("FAIL hold_entry got=%0d/%h/%h/%h/%b want=3/0/0/0/0", state, k0, k1, k2, ut_valid); end
    total++; if ({out, rt} !== {32'h102, 16'd9}) begin
      bad++; $display("FAIL hold_frozen got=%h/%h want=102/9", out, rt); end
    tick();
    total++; if (out !== 32'h102) begin bad++; $display("FAIL hold_frozen2 got=%h want=102", out); end
    hold = 1'b0;
    tick();
    total++; if ({state, pid_rstn, k0, k1, ut_valid} !== {2'd1, 1'b1, 16'd3, 16'hFFFE, 1'b0}) begin
      bad++; $display("FAIL hold_exit got=%0d/%b/%h/%h/%b want=1/1/3/fffe/0", state, pid_rstn, k0, k1, ut_valid); end
    for (int i = 0; i < 11; i++) begin
      tick();
      total++; if ({state, ut_valid} !== {2'd1, 1'b0}) begin
        bad++; $display("FAIL refill i=%0d got=%0d/%b want=1/0", i, state, ut_valid); end
    end
    hold = 1'b1;
    tick();
    total++; if (state !== 2'd3) begin bad++; $display("FAIL hold_prio got=%0d want=3", state); end
    hold = 1'b0;
    tick();
    for (int i = 0; i < 11; i++) tick();
    total++; if (state !== 2'd1) begin bad++; $display("FAIL refill2 got=%0d want=1", state); end
    tick();
    total++; if ({state, ut_valid, out} !== {2'd2, 1'b1, 32'h0000_DEAD}) begin
      bad++; $display("FAIL resume got=%0d/%b/%h want=2/1/dead", state, ut_valid, out); end
  endtask

  task automatic test_decimation();
    logic [7:0] pat;
    pat = 8'b0001_0001;
    hold = 1'b1;
    wr(3'd7, 32'd3); commit();
    hold = 1'b0;
    tick();
    for (int i = 0; i < 12; i++) tick();
    for (int i = 0; i < 8; i++) begin
      total++; if ({state, ut_valid} !== {2'd2, pat[i]}) begin
        bad++; $display("FAIL div3 i=%0d got=%0d/%b want=2/%b", i, state, ut_valid, pat[i]); end
      tick();
    end
    wr(3'd7, 32'd0); commit();
    for (int i = 0; i < 5; i++) tick();
    for (int i = 0; i < 4; i++) begin
      total++; if (ut_valid !== 1'b1) begin bad++; $display("FAIL div0 i=%0d got=%b want=1", i, ut_valid); end
      tick();
    end
  endtask

  task automatic test_disable();
    enable = 1'b0;
    tick();
    total++; if ({state, pid_rstn, out, ut_valid} !== 36'h0) begin
      bad++; $display("FAIL dis_run got=%0d/%b/%h/%b want=0/0/0/0", state, pid_rstn, out, ut_valid); end
    enable = 1'b1;
    tick();
    total++; if ({state, pid_rstn} !== 3'b000) begin
      bad++; $display("FAIL off_min got=%0d/%b want=0/0", state, pid_rstn); end
    tick();
    total++; if ({state, pid_rstn} !== {2'd1, 1'b1}) begin
      bad++; $display("FAIL off_exit got=%0d/%b want=1/1", state, pid_rstn); end
    for (int i = 0; i < 4; i++) tick();
    enable = 1'b0;
    tick();
    total++; if ({state, pid_rstn, out} !== 35'h0) begin
      bad++; $display("FAIL dis_fill got=%0d/%b/%h want=0/0/0", state, pid_rstn, out); end
  endtask

  task automatic test_async_reset();
    enable = 1'b1; ut = 32'h1234_5678;
    tick(); tick();
    for (int i = 0; i < 12; i++) tick();
    total++; if ({state, out} !== {2'd2, 32'h1234_5678}) begin
      bad++; $display("FAIL rerun got=%0d/%h want=2/12345678", state, out); end
    wr(3'd6, 32'hFFFF_FFF6); commit();
    total++; if ({cfg_err, omax} !== {1'b1, 32'd200}) begin
      bad++; $display("FAIL neg_reject got=%b/%h want=1/c8", cfg_err, omax); end
    #2 rstn = 1'b0;
    #1;
    total++; if ({pid_rstn, out, ut_valid, cfg_err, state} !== 36'h0) begin
      bad++; $display("FAIL async_outs got=%h want=0", {pid_rstn, out, ut_valid, cfg_err, state}); end
    total++; if ({rt, k0, k1, k2, shift, omin, omax} !== '0) begin
      bad++; $display("FAIL async_cfg got=%h want=0", {rt, k0, k1, k2, shift, omin, omax}); end
    tick();
    rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b0; enable = 1'b0; hold = 1'b0; ut = '0;
    host.i_wr_en = 1'b0; host.i_wr_addr = '0; host.i_wr_data = '0; host.i_commit = 1'b0;
    test_reset();
    test_commit_gains();
    test_limits();
    test_wr_commit_same();
    test_fill_run();
    test_hold();
    test_decimation();
    test_disable();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pid_seq_ctrl.md
# pid_seq_ctrl

Configuration and sequencing controller for the PID_16 incremental PID core. It holds host-written shadow copies of all PID parameters and commits them atomically to active registers. It sequences the core through reset, pipeline fill, run and hold, and republishes the core output with a qualified, decimated valid strobe. It sits between the host register bus and the PID core; the core's output feeds back through this block to downstream consumers.

## Interface
- WIDTH, 16: PID data width; gains and setpoint are WIDTH bits, limits and output are 2*WIDTH bits.
- SHIFT, 5: width of the output shift field.
- LAT, 12: PID core input-to-output latency in cycles; sets the fill length.
- CNTW, 16: width of the decimation divider and internal counters.
- i_clkp  in  1  single clock, rising edge.
- i_rstn  in  1  asynchronous, active-low reset.
- i_enable  in  1  level; high requests operation.
- i_hold  in  1  level; high freezes the control output.
- i_wr_en  in  1  host write strobe, one word per cycle.
- i_wr_addr  in  3  shadow register address.
- i_wr_data  in  32  write data; narrower registers take the LSBs.
- i_commit  in  1  single-cycle pulse; copies shadow to active.
- i_ut  in  2*WIDTH  PID core output.
- o_pid_rstn  out  1  reset to PID core, registered.
- o_rt, o_k0, o_k1, o_k2  out  WIDTH each  active setpoint and gains to the core.
- o_shift  out  SHIFT  active shift.
- o_min, o_max  out  2*WIDTH  active limits.
- o_ut  out  2*WIDTH  published control output.
- o_ut_valid  out  1  one-cycle qualifier for o_ut.
- o_state  out  2  OFF=0, FILL=1, RUN=2, HOLD=3.
- o_cfg_err  out  1  sticky flag for a rejected commit.

## Operation
- Address map:
  - 0 rt, 1 k0, 2 k1, 3 k2: WIDTH bits each.
  - 4 shift: SHIFT bits.
  - 5 min, 6 max: 2*WIDTH bits each.
  - 7 div: CNTW bits.
- Writes affect shadow registers only. Active registers change only on an accepted commit.
- Commit check:
  - A commit is rejected if shadow min >= shadow max (signed) and the limits are not both zero.
  - On rejection, active registers are unchanged and o_cfg_err sets.
  - Any accepted commit clears o_cfg_err.
- If i_wr_en and i_commit occur in the same cycle, the commit copies the shadow value from before that write.
- Commits are accepted in every state.
- State machine:
  - OFF: o_pid_rstn=0 and o_ut=0. Go to FILL when i_enable=1 and at least 2 cycles have been spent in OFF.
  - FILL: o_pid_rstn=1. Count LAT cycles, then go to RUN.
  - RUN: o_ut follows i_ut. Go to HOLD on i_hold=1.
  - HOLD: o_k0, o_k1 and o_k2 are forced to 0 so the core accumulator stops. o_ut is frozen at its last RUN value. On i_hold=0, go to FILL with o_pid_rstn still high, then to RUN after LAT cycles.
  - i_enable=0 in any state: go to OFF on the next edge. o_ut clears to 0 and o_ut_valid drops.
- i_hold has priority over FILL completion: if i_hold=1 when the LAT count completes, go to HOLD instead of RUN.
- Decimation: in RUN, o_ut_valid pulses once every div+1 cycles, starting on the first RUN cycle. div=0 gives valid every cycle. The divider counter restarts on RUN entry. A div change takes effect at the next counter reload.
- Signed arithmetic is used for the min/max comparison only; all other fields pass through unchanged.

## Timing
- Reset values:
  - Shadow and active registers: 0.
  - o_pid_rstn, o_ut, o_ut_valid, o_cfg_err: 0.
  - o_state: OFF.
- Commit accepted at edge N: the active outputs show the new values from cycle N+1.
- o_ut is i_ut registered, 1 cycle. o_ut_valid is aligned with o_ut.
- OFF to FILL: o_pid_rstn rises at the edge of the state change.
- FILL length is exactly LAT cycles, so the first RUN output reflects a full core pipeline.
- HOLD entry: gains read 0 from the next cycle, and o_ut is frozen at the value from the last RUN cycle.
- Reset asserted mid-operation: all state returns to the reset values immediately (asynchronous). Pending writes and commits are lost.

## Structure
- Shared package: state encoding, address constants, default LAT.
- One sub-module, pid_cfg_bank: shadow registers, active registers and commit check. The FSM, fill counter and decimator stay in the top level.

## Test plan
- Reset, then write k0=3, k1=-2, k2=1 with no commit -> o_k* stay 0. Commit -> o_k0=3, o_k1=0xFFFE, o_k2=1 on the next cycle.
- Write min=100, max=50 and commit -> active limits unchanged and o_cfg_err=1. Write max=200 and commit -> limits 100/200 and o_cfg_err=0.
- Raise i_enable after reset -> 2 cycles in OFF, o_pid_rstn rises, 12 cycles in FILL, then RUN. The first o_ut_valid appears on the first RUN cycle.
- With div=3 in RUN -> o_ut_valid pulses every 4 cycles. With div=0 -> o_ut_valid stays high every cycle.
- Raise i_hold in RUN -> o_k* read 0 and o_ut is frozen. Drop i_hold -> gains restored, 12 cycles in FILL with no valid, then RUN resumes.
- Drop i_enable mid-FILL -> OFF on the next edge with o_pid_rstn=0 and o_ut=0. Pulse i_rstn mid-RUN -> all outputs return to the reset values immediately.
